// File: rtl/fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StHold,
    StDrain
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_entry_t;

endpackage

// File: rtl/fetch_ctrl_if_id_buf.sv
// IF/ID pipeline register with a single-entry skid slot, valid/ready handshake and flush.
module fetch_ctrl_if_id_buf
  import fetch_ctrl_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  input  if_id_entry_t in_entry_i,
  output logic         in_ready_o,
  input  logic         id_ready_i,
  output logic         id_valid_o,
  output if_id_entry_t id_entry_o
);

  logic         out_valid_q, out_valid_d;
  if_id_entry_t out_q, out_d;
  logic         skid_valid_q, skid_valid_d;
  if_id_entry_t skid_q, skid_d;

  // Input goes straight to the output register whenever that register is empty or draining.
  assign in_ready_o = !out_valid_q || id_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (id_ready_i) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end
    end else if (in_valid_i) begin
      if (in_ready_o) begin
        out_d       = in_entry_i;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = in_entry_i;
        skid_valid_d = 1'b1;
      end
    end else if (id_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

  assign id_valid_o = out_valid_q;
  assign id_entry_o = out_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch FSM: one outstanding imem request, redirect flush/drain, feeds IF/ID buffer.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] current_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        id_ready
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         imem_req_q;
  logic         buf_in_valid;
  logic         buf_in_ready;
  logic         flush;
  if_id_entry_t buf_in_entry;
  if_id_entry_t id_entry;

  assign buf_in_entry = '{pc: pc_q, inst: imem_rdata};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_in_valid = 1'b0;
    flush        = 1'b0;
    unique case (state_q)
      StFetch: state_d = redirect ? StDrain : StWait;
      StWait: begin
        if (redirect) begin
          state_d = imem_valid ? StFetch : StDrain;
        end else if (imem_valid) begin
          buf_in_valid = 1'b1;
          if (buf_in_ready) begin
            pc_d    = next_pc;
            state_d = StFetch;
          end else begin
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (redirect) begin
          state_d = StFetch;
        end else if (id_ready) begin
          pc_d    = next_pc;
          state_d = StFetch;
        end
      end
      StDrain: begin
        if (imem_valid) state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
    // Redirect overrides every other PC update and flushes IF/ID plus the skid slot.
    if (redirect) begin
      pc_d  = next_pc;
      flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StFetch;
      pc_q       <= RESET_PC;
      imem_req_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      imem_req_q <= (state_d == StFetch);
    end
  end

  fetch_ctrl_if_id_buf u_if_id_buf (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (buf_in_valid),
    .in_entry_i (buf_in_entry),
    .in_ready_o (buf_in_ready),
    .id_ready_i (id_ready),
    .id_valid_o (id_valid),
    .id_entry_o (id_entry)
  );

  assign current_pc = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = imem_req_q;
  assign id_pc      = id_entry.pc;
  assign id_inst    = id_entry.inst;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with a latency-configurable memory model and PC scoreboard.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] next_pc;
  logic        redirect = 1'b0;
  logic [31:0] redir_target = 32'h0;
  logic [31:0] current_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready = 1'b1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t got;
  exp_t want;

  int          mem_lat = 1;
  logic        mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr_q = 32'h0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .next_pc    (next_pc),
    .redirect   (redirect),
    .current_pc (current_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_ready   (id_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 8) | 32'h0000_0013;
  endfunction

  // if_stage model: sequential PC unless a branch resolves.
  always_comb next_pc = redirect ? redir_target : current_pc + 32'd4;

  always @(posedge clk) begin
    if (rst) begin
      imem_valid <= 1'b0;
      imem_rdata <= 32'h0;
      mem_pend   <= 1'b0;
      mem_cnt    <= 0;
    end else begin
      imem_valid <= 1'b0;
      if (mem_pend) begin
        if (mem_cnt == 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(mem_addr_q);
          mem_pend   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 1;
        end
      end
      if (imem_req) begin
        if (mem_lat <= 1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(imem_addr);
        end else begin
          mem_pend   <= 1'b1;
          mem_cnt    <= mem_lat - 1;
          mem_addr_q <= imem_addr;
        end
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    id_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    id_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (current_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc: got %h want %h", current_pc, 32'h0);
    end
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid);
    end
    checks++;
    if (id_pc !== 32'h0 || id_inst !== 32'h0) begin
      errors++; $display("FAIL reset_id_regs: got pc %h inst %h want 0 0", id_pc, id_inst);
    end
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL reset_first_req: got %b want 1", imem_req);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(i * 4), inst: mem_word(32'(i * 4))});
    for (int c = 0; c < 7; c++) begin
      checks++;
      if (imem_req !== (c % 2 == 0)) begin
        errors++; $display("FAIL seq_req c%0d: got %b want %b", c, imem_req, (c % 2 == 0));
      end
      if (c == 2) begin
        checks++;
        if (id_valid !== 1'b1) begin
          errors++; $display("FAIL seq_latency: got id_valid %b want 1", id_valid);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        got = '{pc: id_pc, inst: id_inst};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL seq_sb: unexpected transfer pc %h", id_pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL seq_sb: got %h/%h want %h/%h", got.pc, got.inst, want.pc,
                               want.inst);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL seq_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic [10:0] req_exp;
    req_exp = 11'b101_0000_0101;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back('{pc: 32'(i * 4), inst: mem_word(32'(i * 4))});
    for (int c = 0; c < 11; c++) begin
      id_ready = !(c >= 2 && c <= 6);
      checks++;
      if (imem_req !== req_exp[c]) begin
        errors++; $display("FAIL stall_req c%0d: got %b want %b", c, imem_req, req_exp[c]);
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0000_0013) begin
          errors++; $display("FAIL stall_hold c%0d: got %b/%h want 1/00000013", c, id_valid,
                             id_inst);
        end
      end
      if (c == 5) begin
        checks++;
        if (current_pc !== 32'h4) begin
          errors++; $display("FAIL stall_pc: got %h want 00000004", current_pc);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        got = '{pc: id_pc, inst: id_inst};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_sb: unexpected transfer pc %h", id_pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL stall_sb: got %h/%h want %h/%h", got.pc, got.inst, want.pc,
                               want.inst);
          end
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL stall_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_wait();
    logic [6:0] req_exp;
    req_exp = 7'b100_1001;
    mem_lat = 2;
    do_reset();
    exp_q.push_back('{pc: 32'h100, inst: mem_word(32'h100)});
    for (int c = 0; c < 7; c++) begin
      redirect     = (c == 1);
      redir_target = 32'h100;
      checks++;
      if (imem_req !== req_exp[c]) begin
        errors++; $display("FAIL rdw_req c%0d: got %b want %b", c, imem_req, req_exp[c]);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (id_valid !== 1'b0) begin
          errors++; $display("FAIL rdw_id_valid c%0d: got %b want 0", c, id_valid);
        end
      end
      if (c == 3) begin
        checks++;
        if (imem_addr !== 32'h100) begin
          errors++; $display("FAIL rdw_addr: got %h want 00000100", imem_addr);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        got = '{pc: id_pc, inst: id_inst};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rdw_sb: unexpected transfer pc %h", id_pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL rdw_sb: got %h/%h want %h/%h", got.pc, got.inst, want.pc,
                               want.inst);
          end
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    mem_lat  = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rdw_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_valid();
    do_reset();
    exp_q.push_back('{pc: 32'h200, inst: mem_word(32'h200)});
    for (int c = 0; c < 5; c++) begin
      redirect     = (c == 1);
      redir_target = 32'h200;
      if (c == 2) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
          errors++; $display("FAIL rdv_req: got %b/%h want 1/00000200", imem_req, imem_addr);
        end
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (id_valid !== 1'b0) begin
          errors++; $display("FAIL rdv_id_valid c%0d: got %b want 0", c, id_valid);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        got = '{pc: id_pc, inst: id_inst};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rdv_sb: unexpected transfer pc %h", id_pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL rdv_sb: got %h/%h want %h/%h", got.pc, got.inst, want.pc,
                               want.inst);
          end
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rdv_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: mem_word(32'hFFFF_FFFC)});
    exp_q.push_back('{pc: 32'h0, inst: mem_word(32'h0)});
    for (int c = 0; c < 7; c++) begin
      redirect     = (c == 1);
      redir_target = 32'hFFFF_FFFC;
      if (c == 2) begin
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
          errors++; $display("FAIL wrap_top: got %h want fffffffc", imem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
          errors++; $display("FAIL wrap_addr: got %b/%h want 1/00000000", imem_req, imem_addr);
        end
      end
      if (id_valid && id_ready) begin
        checks++;
        got = '{pc: id_pc, inst: id_inst};
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL wrap_sb: unexpected transfer pc %h", id_pc);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errors++; $display("FAIL wrap_sb: got %h/%h want %h/%h", got.pc, got.inst, want.pc,
                               want.inst);
          end
        end
      end
      @(negedge clk);
    end
    redirect = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wrap_drain: %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      id_ready = (c < 2);
      @(negedge clk);
    end
    checks++;
    if (current_pc !== 32'h4 || imem_req !== 1'b0 || id_valid !== 1'b1) begin
      errors++; $display("FAIL hold_entry: got pc %h req %b v %b want 00000004 0 1", current_pc,
                         imem_req, id_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (current_pc !== 32'h0 || id_valid !== 1'b0 || imem_req !== 1'b1) begin
      errors++; $display("FAIL hold_reset: got pc %h v %b req %b want 00000000 0 1", current_pc,
                         id_valid, imem_req);
    end
    checks++;
    if (id_inst !== 32'h0 || id_pc !== 32'h0) begin
      errors++; $display("FAIL hold_reset_regs: got %h/%h want 0/0", id_pc, id_inst);
    end
    id_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_valid();
    test_wrap();
    test_reset_in_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
